// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the multi-channel 1-D convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  // Never returns 0 so that single-entry selectors still get a 1-bit port.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int min_acc_w(input int data_w, input int w_w,
                                   input int in_shift, input int k);
    return data_w + in_shift + w_w + clog2(k) + 1;
  endfunction

  function automatic int n_outputs(input int in_len, input int k);
    return in_len - k + 1;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One output channel: K weights, bias, tap accumulator and the bias/ReLU output register.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int K        = 3,
  parameter int DATA_W   = 8,
  parameter int W_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 30,
  parameter int IN_SHIFT = 9,
  parameter int RELU_EN  = 1,
  parameter int TAP_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_we,
  input  logic [TAP_W-1:0]         w_tap,
  input  logic signed [W_W-1:0]    w_data,
  input  logic                     b_we,
  input  logic signed [B_W-1:0]    b_data,
  input  logic                     acc_clr,
  input  logic                     mac_en,
  input  logic                     last_tap,
  input  logic [TAP_W-1:0]         tap,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [ACC_W-1:0]  out_data
);

  logic signed [W_W-1:0]                  w [K];
  logic signed [B_W-1:0]                  bias;
  logic signed [ACC_W-1:0]                acc;

  logic signed [DATA_W+IN_SHIFT-1:0]      xs;
  logic signed [B_W+IN_SHIFT-1:0]         bs;
  logic signed [DATA_W+IN_SHIFT+W_W-1:0]  prod;
  logic signed [ACC_W-1:0]                acc_sum;
  logic signed [ACC_W-1:0]                fin;

  always_comb begin
    xs      = {sample, {IN_SHIFT{1'b0}}};
    bs      = {bias, {IN_SHIFT{1'b0}}};
    prod    = xs * w[tap];
    acc_sum = acc + ACC_W'(prod);
    fin     = acc_sum + ACC_W'(bs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < K; i++) w[i] <= '0;
      bias     <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      if (w_we) w[w_tap] <= w_data;
      if (b_we) bias <= b_data;
      if (acc_clr)     acc <= '0;
      else if (mac_en) acc <= acc_sum;
      // The final tap's product and the bias fold straight into the output register.
      if (mac_en && last_tap)
        out_data <= (RELU_EN != 0 && fin < 0) ? '0 : fin;
    end
  end

endmodule

// File: rtl/conv1d_mc_engine.sv
// Multi-channel 1-D convolution engine: sample window, layer controller and N_CH MAC lanes.
module conv1d_mc_engine
  import conv_pkg::*;
#(
  parameter int N_CH     = 16,
  parameter int K        = 3,
  parameter int DATA_W   = 8,
  parameter int W_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 30,
  parameter int IN_SHIFT = 9,
  parameter int IN_LEN   = 42,
  parameter int RELU_EN  = 1,
  localparam int CH_W    = clog2(N_CH),
  localparam int TAP_W   = clog2(K)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   w_we,
  input  logic [CH_W-1:0]        w_ch,
  input  logic [TAP_W-1:0]       w_tap,
  input  logic [W_W-1:0]         w_data,
  input  logic                   b_we,
  input  logic [CH_W-1:0]        b_ch,
  input  logic [B_W-1:0]         b_data,
  output logic [N_CH*ACC_W-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [10:0]            out_idx,
  output logic                   busy,
  output logic                   layer_done
);

  localparam int N_OUT = n_outputs(IN_LEN, K);
  localparam int FC_W  = clog2(K + 1);

  if (ACC_W < min_acc_w(DATA_W, W_W, IN_SHIFT, K)) begin : g_acc_w_check
    $error("conv1d_mc_engine: ACC_W too narrow for full-precision accumulation");
  end

  state_t                   state, state_nx;
  logic [FC_W-1:0]          fill_cnt, fill_nx;
  logic [TAP_W-1:0]         tap, tap_nx;
  logic [10:0]              out_cnt, out_nx;
  logic signed [DATA_W-1:0] win [K];

  logic accept, acc_clr, mac_en, last_tap;
  logic w_ok, b_ok;

  assign accept     = in_valid && (state == S_FILL);
  assign busy       = (state != S_IDLE);
  assign out_idx    = out_cnt;
  assign w_ok       = w_we && (state == S_IDLE) && (32'(w_ch) < N_CH) && (32'(w_tap) < K);
  assign b_ok       = b_we && (state == S_IDLE) && (32'(b_ch) < N_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fill_cnt <= '0;
      tap      <= '0;
      out_cnt  <= '0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_nx;
      tap      <= tap_nx;
      out_cnt  <= out_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    fill_nx    = fill_cnt;
    tap_nx     = tap;
    out_nx     = out_cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    layer_done = 1'b0;
    acc_clr    = 1'b0;
    mac_en     = 1'b0;
    last_tap   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_FILL;
          fill_nx  = '0;
          out_nx   = '0;
        end
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (accept) begin
          fill_nx = fill_cnt + 1'b1;
          if (fill_cnt == FC_W'(K - 1)) begin
            state_nx = S_MAC;
            tap_nx   = '0;
            acc_clr  = 1'b1;
          end
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        tap_nx = tap + 1'b1;
        if (tap == TAP_W'(K - 1)) begin
          last_tap = 1'b1;
          state_nx = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_cnt == 11'(N_OUT - 1)) begin
            state_nx = S_DONE;
          end else begin
            // Window already holds K-1 valid samples; one more completes the next output.
            out_nx   = out_cnt + 1'b1;
            fill_nx  = FC_W'(K - 1);
            state_nx = S_FILL;
          end
        end
      end
      S_DONE: begin
        layer_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < K; i++) win[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i + 1 < K; i++) win[i] <= win[i+1];
      win[K-1] <= in_data;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    logic signed [ACC_W-1:0] lane_out;

    conv_mac_lane #(
      .K       (K),
      .DATA_W  (DATA_W),
      .W_W     (W_W),
      .B_W     (B_W),
      .ACC_W   (ACC_W),
      .IN_SHIFT(IN_SHIFT),
      .RELU_EN (RELU_EN),
      .TAP_W   (TAP_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .w_we    (w_ok && (w_ch == CH_W'(c))),
      .w_tap   (w_tap),
      .w_data  (w_data),
      .b_we    (b_ok && (b_ch == CH_W'(c))),
      .b_data  (b_data),
      .acc_clr (acc_clr),
      .mac_en  (mac_en),
      .last_tap(last_tap),
      .tap     (tap),
      .sample  (win[tap]),
      .out_data(lane_out)
    );

    assign out_data[c*ACC_W +: ACC_W] = lane_out;
  end

endmodule

// File: tb/tb_conv1d_mc_engine.sv
// Directed/random bench for conv1d_mc_engine against an arithmetic convolution model.
module tb_conv1d_mc_engine;
  localparam int N_CH = 16, K = 3, DATA_W = 8, W_W = 8, B_W = 8;
  localparam int ACC_W = 30, IN_SHIFT = 9, IN_LEN = 42;
  localparam int VW = N_CH * ACC_W;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic in_valid = 1'b0, w_we = 1'b0, b_we = 1'b0, out_ready = 1'b0;
  logic [3:0] w_ch = '0, b_ch = '0;
  logic [1:0] w_tap = '0;
  logic [W_W-1:0] w_data = '0;
  logic [B_W-1:0] b_data = '0;

  logic in_ready, out_valid, busy, layer_done;
  logic [VW-1:0] out_data;
  logic [10:0] out_idx;
  logic in_ready_nr, out_valid_nr, busy_nr, layer_done_nr;
  logic [VW-1:0] out_data_nr;
  logic [10:0] out_idx_nr;

  int n_chk = 0, n_fail = 0, ld_cnt = 0;
  int wm[N_CH][K];
  int bm[N_CH];
  int win_q[$];

  always #5 clk = ~clk;

  conv1d_mc_engine #(.N_CH(N_CH), .K(K), .DATA_W(DATA_W), .W_W(W_W), .B_W(B_W), .ACC_W(ACC_W),
                     .IN_SHIFT(IN_SHIFT), .IN_LEN(IN_LEN), .RELU_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .w_we(w_we), .w_ch(w_ch), .w_tap(w_tap), .w_data(w_data),
    .b_we(b_we), .b_ch(b_ch), .b_data(b_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .busy(busy), .layer_done(layer_done));

  conv1d_mc_engine #(.N_CH(N_CH), .K(K), .DATA_W(DATA_W), .W_W(W_W), .B_W(B_W), .ACC_W(ACC_W),
                     .IN_SHIFT(IN_SHIFT), .IN_LEN(IN_LEN), .RELU_EN(0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_nr), .w_we(w_we), .w_ch(w_ch), .w_tap(w_tap), .w_data(w_data),
    .b_we(b_we), .b_ch(b_ch), .b_data(b_data), .out_data(out_data_nr), .out_valid(out_valid_nr),
    .out_ready(out_ready), .out_idx(out_idx_nr), .busy(busy_nr), .layer_done(layer_done_nr));

  always @(negedge clk) if (layer_done === 1'b1) ld_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input bit ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic logic [VW-1:0] model_vec(input bit relu);
    logic [VW-1:0] v;
    logic [63:0] sv;
    longint s;
    v = '0;
    for (int c = 0; c < N_CH; c++) begin
      s = longint'(bm[c]) * (1 << IN_SHIFT);
      for (int t = 0; t < K; t++)
        s += longint'(win_q[t]) * (1 << IN_SHIFT) * longint'(wm[c][t]);
      if (relu && s < 0) s = 0;
      sv = s;
      v[c*ACC_W +: ACC_W] = sv[ACC_W-1:0];
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int ch, input int tap, input int val, input bit effective);
    w_we = 1'b1; w_ch = 4'(ch); w_tap = 2'(tap); w_data = 8'(val);
    tick();
    w_we = 1'b0;
    if (effective) wm[ch][tap] = val;
  endtask

  task automatic write_b(input int ch, input int val);
    b_we = 1'b1; b_ch = 4'(ch); b_data = 8'(val);
    tick();
    b_we = 1'b0;
    bm[ch] = val;
  endtask

  task automatic send_sample(input int v);
    int waited;
    repeat ($urandom_range(0, 2)) tick();
    in_valid = 1'b1;
    in_data  = 8'(v);
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    chk("accept_ready", in_ready === 1'b1);
    tick();
    in_valid = 1'b0;
    win_q.push_back(v);
    if (win_q.size() > K) void'(win_q.pop_front());
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
      chk("in_ready_low_mac_out", in_ready === 1'b0);
    end while (out_valid !== 1'b1 && lat < 50);
    chk("out_valid_seen", out_valid === 1'b1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid === 1'b0);
  endtask

  task automatic check_vec(input int idx);
    chk("out_vec_relu", out_data === model_vec(1'b1));
    chk("out_vec_norelu", out_data_nr === model_vec(1'b0));
    chk("out_idx", out_idx === 11'(idx));
  endtask

  initial begin
    int lat, n_out, v;
    logic [VW-1:0] hold_d;
    logic [10:0] hold_i;

    for (int c = 0; c < N_CH; c++) begin
      bm[c] = 0;
      for (int t = 0; t < K; t++) wm[c][t] = 0;
    end

    repeat (3) tick();
    chk("rst_out_data", out_data === {VW{1'b0}});
    chk("rst_out_valid", out_valid === 1'b0);
    chk("rst_in_ready", in_ready === 1'b0);
    chk("rst_busy", busy === 1'b0);
    chk("rst_layer_done", layer_done === 1'b0);
    chk("rst_out_idx", out_idx === 11'd0);
    rst_n = 1'b1;
    tick();

    write_w(0, 0, 1, 1'b1); write_w(0, 1, 2, 1'b1); write_w(0, 2, 3, 1'b1);
    write_b(0, 1);
    write_w(0, 3, 55, 1'b0);
    for (int t = 0; t < K; t++) write_w(1, t, -1, 1'b1);
    write_b(1, 0);
    for (int c = 2; c < N_CH; c++) begin
      for (int t = 0; t < K; t++) write_w(c, t, int'($urandom_range(0, 255)) - 128, 1'b1);
      write_b(c, int'($urandom_range(0, 255)) - 128);
    end

    in_valid = 1'b1; in_data = 8'd77;
    tick();
    chk("idle_in_ready", in_ready === 1'b0);
    in_valid = 1'b0;

    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", busy === 1'b1);

    send_sample(1); send_sample(2); send_sample(3);
    wait_out(lat);
    chk("first_latency", lat == K);
    chk("ch0_first", out_data[0 +: ACC_W] === 30'd7680);
    chk("ch1_relu", out_data[ACC_W +: ACC_W] === 30'd0);
    chk("ch1_norelu", $signed(out_data_nr[ACC_W +: ACC_W]) === -3072);
    check_vec(0);

    hold_d = out_data; hold_i = out_idx;
    in_valid = 1'b1; in_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_stable", (out_valid === 1'b1) && (in_ready === 1'b0) &&
                         (out_data === hold_d) && (out_idx === hold_i));
    end
    in_valid = 1'b0;
    handshake();

    send_sample(4);
    w_we = 1'b1; w_ch = 4'd0; w_tap = 2'd0; w_data = 8'd100; start = 1'b1;
    tick();
    w_we = 1'b0; start = 1'b0;
    wait_out(lat);
    chk("ch0_second", out_data[0 +: ACC_W] === 30'd10752);
    check_vec(1);
    handshake();
    n_out = 2;

    for (int n = 2; n < IN_LEN - K + 1; n++) begin
      v = int'($urandom_range(0, 255)) - 128;
      send_sample(v);
      wait_out(lat);
      check_vec(n);
      repeat ($urandom_range(0, 3)) tick();
      handshake();
      n_out++;
      if (n == IN_LEN - K) begin
        chk("layer_done_pulse", {layer_done, busy} === 2'b11);
        tick();
        chk("idle_after_done", {layer_done, busy} === 2'b00);
      end
    end
    chk("output_count", n_out == IN_LEN - K + 1);
    chk("layer_done_count", ld_cnt == 1);

    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < K; i++) send_sample(int'($urandom_range(0, 255)) - 128);
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_data", out_data === {VW{1'b0}});
    chk("rst_mid_flags", {out_valid, in_ready, busy, layer_done} === 4'b0000);
    chk("rst_mid_idx", out_idx === 11'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      bm[c] = 0;
      for (int t = 0; t < K; t++) wm[c][t] = 0;
    end
    win_q.delete();
    tick();

    write_b(0, 5);
    write_b(2, -7);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < K; i++) send_sample(int'($urandom_range(0, 255)) - 128);
    wait_out(lat);
    chk("bias_only_ch0", out_data[0 +: ACC_W] === 30'd2560);
    check_vec(0);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
